// File: rtl/arbiter_client_port.sv
// -----------------------------------------------------------------------------
// arbiter_client_port
//
// Requester-side endpoint for a round-robin arbiter. Producer words are
// buffered in a DEPTH-entry FIFO. While the FIFO holds anything, req is raised
// towards the arbiter. A grant pops the head word into a registered output
// channel, giving a one-cycle out_valid pulse on the following cycle.
//
// Optional feature (compile-time macro ARB_CLIENT_WAIT_CNT_EN):
//   Tracks how long req stays up without a grant. max_wait reports the
//   longest streak since reset. starved latches once a streak reaches 64.
//   Without the macro both outputs are tied to 0 and no counter exists.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   producer offers in_data this cycle
//   in_data    producer data word
//   in_ready   FIFO can accept a word (count != DEPTH)
//   req        request to arbiter (count != 0)
//   grant      grant from arbiter (combinational response to req)
//   out_valid  one-cycle pulse per popped word
//   out_data   last popped word (held while out_valid = 0)
//   count      current FIFO occupancy
//   max_wait   longest req-without-grant streak (optional feature)
//   starved    wait streak reached 64 (optional feature)
// -----------------------------------------------------------------------------
module arbiter_client_port #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       in_ready,
   output logic                       req,
   input  logic                       grant,
   output logic                       out_valid,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [15:0]                max_wait,
   output logic                       starved
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count_q;
   logic [CNT_W-1:0]  count_next;
   logic              push;
   logic              pop;

   // Both handshakes derive only from registered occupancy, so req never
   // depends on grant and there is no combinational loop through the arbiter.
   assign in_ready = (count_q != FULL_CNT);
   assign req      = (count_q != '0);
   assign push     = in_valid & in_ready;
   // A grant without req is ignored.
   assign pop      = req & grant;
   assign count    = count_q;

   // NOTE: every signal written in always_comb gets a default first so no
   // latch is inferred on any path.
   always_comb begin
      count_next = count_q;
      case ({push, pop})
         2'b10:   count_next = count_q + CNT_W'(1);
         2'b01:   count_next = count_q - CNT_W'(1);
         default: count_next = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q   <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         count_q   <= count_next;
         out_valid <= pop;
         // DEPTH is a power of two, so natural pointer overflow is the wrap.
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) begin
            rd_ptr   <= rd_ptr + PTR_W'(1);
            out_data <= mem[rd_ptr];
         end
      end
   end

   // NOTE: the storage array is deliberately not reset; entries are only read
   // after being written, and leaving it reset-free lets it map to plain RAM.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

`ifdef ARB_CLIENT_WAIT_CNT_EN
   logic [15:0] wait_cnt;
   logic [15:0] wait_next;
   logic [15:0] max_wait_q;
   logic        starved_q;

   // Streak counts cycles of req without grant; any pop or idle cycle ends it.
   always_comb begin
      wait_next = wait_cnt;
      if (!req || pop)
         wait_next = '0;
      else if (wait_cnt != 16'hFFFF)
         wait_next = wait_cnt + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt   <= '0;
         max_wait_q <= '0;
         starved_q  <= 1'b0;
      end else begin
         wait_cnt <= wait_next;
         // Compare against the next value so max_wait tracks the streak
         // in the same cycle the counter reaches it.
         if (wait_next > max_wait_q) max_wait_q <= wait_next;
         if (wait_next >= 16'd64)    starved_q  <= 1'b1;
      end
   end

   assign max_wait = max_wait_q;
   assign starved  = starved_q;
`else
   assign max_wait = '0;
   assign starved  = 1'b0;
`endif

endmodule

// File: tb/tb_arbiter_client_port.sv
// -----------------------------------------------------------------------------
// tb_arbiter_client_port
//
// Self-checking bench for arbiter_client_port (DATA_W=32, DEPTH=4).
// A directed vector table covers the single-word and fill/stall sequences;
// hand-written sequences cover wrap/ordering, push+pop at count 2, mid-run
// reset and a long starvation streak; a randomized phase runs against a
// queue-based reference model. Honours ARB_CLIENT_WAIT_CNT_EN for the
// max_wait / starved expectations.
// -----------------------------------------------------------------------------
module tb_arbiter_client_port;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              req;
   logic              grant;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  count;
   logic [15:0]       max_wait;
   logic              starved;

   arbiter_client_port #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .req       (req),
      .grant     (grant),
      .out_valid (out_valid),
      .out_data  (out_data),
      .count     (count),
      .max_wait  (max_wait),
      .starved   (starved)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: the FIFO is a queue, the wait streak a plain integer.
   logic [DATA_W-1:0] mq[$];
   logic              m_valid;
   logic [DATA_W-1:0] m_data;
   int                m_streak;
   int                m_max;
   logic              m_starved;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_valid   = 1'b0;
      m_data    = '0;
      m_streak  = 0;
      m_max     = 0;
      m_starved = 1'b0;
   endtask

   // Apply inputs at the falling edge, then advance the model across the
   // rising edge using the inputs that the DUT sees.
   task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic g);
      logic m_req, m_push, m_pop;
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      grant    = g;
      m_req  = (mq.size() != 0);
      m_push = v && (mq.size() < DEPTH);
      m_pop  = m_req && g;
      @(posedge clk);
      m_valid = m_pop;
      if (m_pop) m_data = mq.pop_front();
      if (m_push) mq.push_back(d);
      if (m_req && !g) m_streak = (m_streak < 65535) ? m_streak + 1 : 65535;
      else             m_streak = 0;
      if (m_streak > m_max) m_max = m_streak;
      if (m_streak >= 64) m_starved = 1'b1;
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".req"},       64'(req),       64'(mq.size() != 0));
      check({tag, ".in_ready"},  64'(in_ready),  64'(mq.size() < DEPTH));
      check({tag, ".count"},     64'(count),     64'(mq.size()));
      check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
      check({tag, ".out_data"},  64'(out_data),  64'(m_data));
`ifdef ARB_CLIENT_WAIT_CNT_EN
      check({tag, ".max_wait"},  64'(max_wait),  64'(m_max));
      check({tag, ".starved"},   64'(starved),   64'(m_starved));
`else
      check({tag, ".max_wait"},  64'(max_wait),  64'd0);
      check({tag, ".starved"},   64'(starved),   64'd0);
`endif
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      grant    = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic              v;
      logic [DATA_W-1:0] d;
      logic              g;
      logic              e_req;
      logic              e_rdy;
      int                e_cnt;
      logic              e_ov;
      logic [DATA_W-1:0] e_od;
   } vec_t;

   vec_t tbl[14];

   initial begin
      // {in_valid, in_data, grant, req, in_ready, count, out_valid, out_data}
      // Expected values are the outputs observed after the clock edge.
      tbl[0]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b1, 1, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 0, 1'b1, 32'hA5A5_0001};
      tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 0, 1'b0, 32'hA5A5_0001};
      tbl[3]  = '{1'b1, 32'd1,         1'b0, 1'b1, 1'b1, 1, 1'b0, 32'hA5A5_0001};
      tbl[4]  = '{1'b1, 32'd2,         1'b0, 1'b1, 1'b1, 2, 1'b0, 32'hA5A5_0001};
      tbl[5]  = '{1'b1, 32'd3,         1'b0, 1'b1, 1'b1, 3, 1'b0, 32'hA5A5_0001};
      tbl[6]  = '{1'b1, 32'd4,         1'b0, 1'b1, 1'b0, 4, 1'b0, 32'hA5A5_0001};
      tbl[7]  = '{1'b1, 32'd5,         1'b0, 1'b1, 1'b0, 4, 1'b0, 32'hA5A5_0001};
      tbl[8]  = '{1'b1, 32'd5,         1'b1, 1'b1, 1'b1, 3, 1'b1, 32'd1};
      tbl[9]  = '{1'b1, 32'd5,         1'b0, 1'b1, 1'b0, 4, 1'b0, 32'd1};
      tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 3, 1'b1, 32'd2};
      tbl[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 2, 1'b1, 32'd3};
      tbl[12] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1, 1'b1, 32'd4};
      tbl[13] = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 0, 1'b1, 32'd5};
   end

   initial begin
      logic [DATA_W-1:0] expect_q[$];
      logic [DATA_W-1:0] nxt;
      int                pushed;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      grant    = 1'b0;
      model_reset();

      // Reset then idle.
      do_reset();
      #1;
      check_model("reset");
      for (int i = 0; i < 4; i++) begin
         step(1'b0, '0, 1'b0);
         check_model("idle");
      end

      // Directed table: single word, grant without req, fill/stall/drain.
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].g);
         check($sformatf("vec%0d.req", i),       64'(req),       64'(tbl[i].e_req));
         check($sformatf("vec%0d.in_ready", i),  64'(in_ready),  64'(tbl[i].e_rdy));
         check($sformatf("vec%0d.count", i),     64'(count),     64'(tbl[i].e_cnt));
         check($sformatf("vec%0d.out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
         check($sformatf("vec%0d.out_data", i),  64'(out_data),  64'(tbl[i].e_od));
      end

      // Wrap and ordering: words 0..9, grant every other cycle; the
      // producer holds a word while full. Outputs must be exactly 0..9.
      expect_q.delete();
      for (int i = 0; i < 10; i++) expect_q.push_back(DATA_W'(i));
      pushed = 0;
      for (int c = 0; c < 60 && expect_q.size() != 0; c++) begin
         logic will_push;
         will_push = (pushed < 10) && (mq.size() < DEPTH);
         step(pushed < 10, DATA_W'(pushed), c[0]);
         if (will_push) pushed++;
         check_model("wrap");
         if (count > CNT_W'(DEPTH)) check("wrap.count_max", 64'(count), 64'(DEPTH));
         if (out_valid) begin
            nxt = expect_q.pop_front();
            check("wrap.order", 64'(out_data), 64'(nxt));
         end
      end
      check("wrap.all_out", 64'(expect_q.size()), 64'd0);

      // Simultaneous push and pop at count 2 with grant held high.
      step(1'b1, 32'h100, 1'b0);
      step(1'b1, 32'h101, 1'b0);
      check("pp.count_start", 64'(count), 64'd2);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 32'h102 + DATA_W'(i), 1'b1);
         check("pp.count_held", 64'(count), 64'd2);
         check("pp.out_data", 64'(out_data), 64'(32'h100 + i));
         check_model("pp");
      end
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      check_model("pp_drain");
      step(1'b0, '0, 1'b1);   // grant with req=0
      check("viol.out_valid", 64'(out_valid), 64'd0);
      check_model("viol");

      // Reset mid-operation: buffered words vanish with no output pulse.
      step(1'b1, 32'hDEAD_0001, 1'b0);
      step(1'b1, 32'hDEAD_0002, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst.count", 64'(count), 64'd0);
      check("midrst.req", 64'(req), 64'd0);
      check("midrst.out_valid", 64'(out_valid), 64'd0);
      model_reset();
      @(negedge clk);
      in_valid = 1'b0;
      grant    = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, '0, 1'b1);
      check_model("post_rst");

      // Long wait: one word, no grant for 70 cycles, then grant.
      step(1'b1, 32'hCAFE_0070, 1'b0);
      for (int i = 1; i <= 70; i++) begin
         step(1'b0, '0, 1'b0);
         check_model("starve");
      end
      step(1'b0, '0, 1'b1);
      check_model("starve_pop");
`ifdef ARB_CLIENT_WAIT_CNT_EN
      check("starve.max_wait_70", 64'(max_wait), 64'd70);
      check("starve.starved", 64'(starved), 64'd1);
`endif

      // Randomized traffic against the reference model.
      for (int i = 0; i < 2000; i++) begin
         step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 2) == 0));
         check_model("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
